// File: rtl/alu_regfile_pkg.sv
// rtl/alu_regfile_pkg.sv - shared CPU data-path constants, types and ALU command encodings
package cpu_pkg;

   localparam int DW = 8;
   localparam int AW = 3;

   typedef logic [AW-1:0] reg_addr_t;
   typedef logic [DW-1:0] data_t;

   typedef enum logic [4:0] {
      ALU_ADD = 5'd0,
      ALU_SUB = 5'd1,
      ALU_AND = 5'd2,
      ALU_XOR = 5'd3,
      ALU_CMP = 5'd4,
      ALU_CEQ = 5'd5,
      ALU_LSL = 5'd6,
      ALU_LSR = 5'd7,
      ALU_MOV = 5'd8
   } alu_cmd_t;

endpackage

// File: rtl/alu_regfile_if.sv
// rtl/alu_regfile_if.sv - register file read/write ports and flag controls between decoder and regfile
interface alu_regfile_if #(
   parameter int DW = cpu_pkg::DW,
   parameter int AW = cpu_pkg::AW
);
   logic          stall;
   logic [AW-1:0] rd_addr_a;
   logic [AW-1:0] rd_addr_b;
   logic [DW-1:0] do_a;
   logic [DW-1:0] do_b;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          sc_we;
   logic          sc_clr;
   logic          sc_in;
   logic          sc_q;
   logic          cnd_we;
   logic          cnd_in;
   logic          cnd_q;
   logic          flag_we;
   logic          zero_q;
   logic          pari_q;

   modport master (
      output stall, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
             sc_we, sc_clr, sc_in, cnd_we, cnd_in, flag_we,
      input  do_a, do_b, sc_q, cnd_q, zero_q, pari_q
   );

   modport slave (
      input  stall, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data,
             sc_we, sc_clr, sc_in, cnd_we, cnd_in, flag_we,
      output do_a, do_b, sc_q, cnd_q, zero_q, pari_q
   );
endinterface

// File: rtl/alu_regfile_flag_bits.sv
// rtl/alu_regfile_flag_bits.sv - shift-carry, condition, zero and parity flag flops
module flag_bits #(
   parameter int DW = cpu_pkg::DW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          sc_we,
   input  logic          sc_clr,
   input  logic          sc_in,
   input  logic          cnd_we,
   input  logic          cnd_in,
   input  logic          flag_we,
   input  logic [DW-1:0] wr_data,
   output logic          sc_q,
   output logic          cnd_q,
   output logic          zero_q,
   output logic          pari_q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sc_q   <= 1'b0;
         cnd_q  <= 1'b0;
         zero_q <= 1'b0;
         pari_q <= 1'b0;
      end else if (!stall) begin
         // clear wins over load so a decoder can flush carry in the same op
         if (sc_clr)
            sc_q <= 1'b0;
         else if (sc_we)
            sc_q <= sc_in;
         if (cnd_we)
            cnd_q <= cnd_in;
         if (flag_we) begin
            zero_q <= (wr_data == '0);
            pari_q <= ^wr_data;
         end
      end
   end

endmodule

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with same-cycle write forwarding and ALU flag stage
module alu_regfile #(
   parameter int DW     = cpu_pkg::DW,
   parameter int AW     = cpu_pkg::AW,
   parameter int BYPASS = 1
) (
   input  logic       clk,
   input  logic       reset,
   alu_regfile_if.slave rf
);

   localparam int NREG = 2 ** AW;

   logic [DW-1:0] regs [NREG];
   logic          wr_fire;

   assign wr_fire = rf.wr_en && !rf.stall;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wr_fire) begin
         regs[rf.wr_addr] <= rf.wr_data;
      end
   end

   // forwarding only when the write will really land, so a stalled write never leaks
   always_comb begin
      rf.do_a = regs[rf.rd_addr_a];
      rf.do_b = regs[rf.rd_addr_b];
      if (BYPASS != 0 && wr_fire) begin
         if (rf.wr_addr == rf.rd_addr_a)
            rf.do_a = rf.wr_data;
         if (rf.wr_addr == rf.rd_addr_b)
            rf.do_b = rf.wr_data;
      end
   end

   flag_bits #(.DW(DW)) u_flags (
      .clk     (clk),
      .reset   (reset),
      .stall   (rf.stall),
      .sc_we   (rf.sc_we),
      .sc_clr  (rf.sc_clr),
      .sc_in   (rf.sc_in),
      .cnd_we  (rf.cnd_we),
      .cnd_in  (rf.cnd_in),
      .flag_we (rf.flag_we),
      .wr_data (rf.wr_data),
      .sc_q    (rf.sc_q),
      .cnd_q   (rf.cnd_q),
      .zero_q  (rf.zero_q),
      .pari_q  (rf.pari_q)
   );

endmodule

// File: tb/tb_alu_regfile.sv
// tb/tb_alu_regfile.sv - directed vector bench for alu_regfile, bypass and non-bypass builds
module tb_alu_regfile;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall, wr_en, sc_we, sc_clr, sc_in, cnd_we, cnd_in, flag_we;
   logic [2:0] rd_a, rd_b, wr_addr;
   logic [7:0] wr_data;

   always #5 clk = ~clk;

   alu_regfile_if #(.DW(8), .AW(3)) bus  ();
   alu_regfile_if #(.DW(8), .AW(3)) bus0 ();

   assign bus.stall  = stall;   assign bus0.stall  = stall;
   assign bus.rd_addr_a = rd_a; assign bus0.rd_addr_a = rd_a;
   assign bus.rd_addr_b = rd_b; assign bus0.rd_addr_b = rd_b;
   assign bus.wr_en  = wr_en;   assign bus0.wr_en  = wr_en;
   assign bus.wr_addr = wr_addr; assign bus0.wr_addr = wr_addr;
   assign bus.wr_data = wr_data; assign bus0.wr_data = wr_data;
   assign bus.sc_we  = sc_we;   assign bus0.sc_we  = sc_we;
   assign bus.sc_clr = sc_clr;  assign bus0.sc_clr = sc_clr;
   assign bus.sc_in  = sc_in;   assign bus0.sc_in  = sc_in;
   assign bus.cnd_we = cnd_we;  assign bus0.cnd_we = cnd_we;
   assign bus.cnd_in = cnd_in;  assign bus0.cnd_in = cnd_in;
   assign bus.flag_we = flag_we; assign bus0.flag_we = flag_we;

   alu_regfile #(.DW(8), .AW(3), .BYPASS(1)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (bus.slave)
   );

   alu_regfile #(.DW(8), .AW(3), .BYPASS(0)) dut0 (
      .clk   (clk),
      .reset (reset),
      .rf    (bus0.slave)
   );

   typedef struct {
      logic       we;
      logic [2:0] wa;
      logic [7:0] wd;
      logic [2:0] ra;
      logic [2:0] rb;
      logic       scwe, sccl, scin, cwe, cin, fwe, st;
      logic [7:0] ea, eb, ea0, eb0;
      logic       esc, ecnd, ez, ep;
   } vec_t;

   vec_t vecs [18];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      stall = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rd_a = 0; rd_b = 0;
      sc_we = 0; sc_clr = 0; sc_in = 0; cnd_we = 0; cnd_in = 0; flag_we = 0;
   endtask

   initial begin
      //           we wa  wd     ra  rb  scwe sccl scin cwe cin fwe st  ea     eb     ea0    eb0    sc cnd z  p
      vecs[0]  = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0};
      vecs[1]  = '{1, 1, 8'hA5, 1, 7, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0};
      vecs[2]  = '{1, 7, 8'h3C, 1, 7, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h3C, 8'hA5, 8'h00, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 8'h00, 1, 7, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0, 0, 0, 0};
      vecs[4]  = '{0, 0, 8'h00, 3, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0};
      vecs[5]  = '{1, 2, 8'h77, 2, 2, 0, 0, 0, 0, 0, 0, 0, 8'h77, 8'h77, 8'h00, 8'h00, 0, 0, 0, 0};
      vecs[6]  = '{0, 0, 8'h00, 2, 5, 0, 0, 0, 0, 0, 0, 0, 8'h77, 8'h00, 8'h77, 8'h00, 0, 0, 0, 0};
      vecs[7]  = '{0, 0, 8'h00, 1, 2, 1, 1, 1, 0, 0, 0, 0, 8'hA5, 8'h77, 8'hA5, 8'h77, 0, 0, 0, 0};
      vecs[8]  = '{0, 0, 8'h00, 1, 2, 1, 0, 1, 0, 0, 0, 0, 8'hA5, 8'h77, 8'hA5, 8'h77, 1, 0, 0, 0};
      vecs[9]  = '{0, 0, 8'h00, 1, 2, 0, 0, 0, 0, 0, 0, 0, 8'hA5, 8'h77, 8'hA5, 8'h77, 1, 0, 0, 0};
      vecs[10] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0};
      vecs[11] = '{0, 0, 8'h07, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1};
      vecs[12] = '{0, 0, 8'h03, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0};
      vecs[13] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
      vecs[14] = '{1, 4, 8'hFF, 4, 4, 0, 1, 0, 1, 0, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0};
      vecs[15] = '{0, 0, 8'h00, 4, 2, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h77, 8'h00, 8'h77, 0, 1, 0, 0};
      vecs[16] = '{1, 0, 8'h01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8'h01, 8'h01, 8'h00, 8'h00, 0, 0, 0, 0};
      vecs[17] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'h01, 8'hA5, 8'h01, 8'hA5, 0, 0, 0, 0};

      idle();
      reset = 1'b1;
      #1;
      check("reset do_a", 32'(bus.do_a), 32'h00);
      check("reset do_b", 32'(bus.do_b), 32'h00);
      check("reset flags", 32'({bus.sc_q, bus.cnd_q, bus.zero_q, bus.pari_q}), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
         rd_a = vecs[i].ra; rd_b = vecs[i].rb; stall = vecs[i].st;
         sc_we = vecs[i].scwe; sc_clr = vecs[i].sccl; sc_in = vecs[i].scin;
         cnd_we = vecs[i].cwe; cnd_in = vecs[i].cin; flag_we = vecs[i].fwe;
         #1;
         check($sformatf("v%0d do_a", i), 32'(bus.do_a), 32'(vecs[i].ea));
         check($sformatf("v%0d do_b", i), 32'(bus.do_b), 32'(vecs[i].eb));
         check($sformatf("v%0d nobyp do_a", i), 32'(bus0.do_a), 32'(vecs[i].ea0));
         check($sformatf("v%0d nobyp do_b", i), 32'(bus0.do_b), 32'(vecs[i].eb0));
         @(posedge clk);
         #1;
         check($sformatf("v%0d sc_q", i), 32'(bus.sc_q), 32'(vecs[i].esc));
         check($sformatf("v%0d cnd_q", i), 32'(bus.cnd_q), 32'(vecs[i].ecnd));
         check($sformatf("v%0d zero_q", i), 32'(bus.zero_q), 32'(vecs[i].ez));
         check($sformatf("v%0d pari_q", i), 32'(bus.pari_q), 32'(vecs[i].ep));
      end

      // asynchronous reset landing between edges after a write and flag loads
      @(negedge clk);
      idle();
      wr_en = 1; wr_addr = 3; wr_data = 8'h5A;
      sc_we = 1; sc_in = 1; cnd_we = 1; cnd_in = 1;
      @(posedge clk);
      #1;
      @(negedge clk);
      idle();
      flag_we = 1; wr_data = 8'h01; rd_a = 3;
      @(posedge clk);
      #1;
      flag_we = 0;
      check("pre-reset do_a R3", 32'(bus.do_a), 32'h5A);
      check("pre-reset flags", 32'({bus.sc_q, bus.cnd_q, bus.zero_q, bus.pari_q}), 32'b1101);
      #1;
      reset = 1'b1;
      #1;
      check("midreset do_a R3", 32'(bus.do_a), 32'h00);
      check("midreset nobyp do_a R3", 32'(bus0.do_a), 32'h00);
      check("midreset flags", 32'({bus.sc_q, bus.cnd_q, bus.zero_q, bus.pari_q}), 32'h0);
      #1;
      reset = 1'b0;

      // stalled cycle: write, carry and condition loads must all be dropped
      @(negedge clk);
      idle();
      stall = 1; wr_en = 1; wr_addr = 4; wr_data = 8'hFF;
      sc_we = 1; sc_in = 1; cnd_we = 1; cnd_in = 1; rd_a = 4; rd_b = 4;
      #1;
      check("stall no bypass do_a", 32'(bus.do_a), 32'h00);
      check("stall no bypass do_b", 32'(bus.do_b), 32'h00);
      @(posedge clk);
      #1;
      check("stall sc_q", 32'(bus.sc_q), 32'h0);
      check("stall cnd_q", 32'(bus.cnd_q), 32'h0);
      @(negedge clk);
      idle();
      rd_a = 4;
      #1;
      check("stall R4 held", 32'(bus.do_a), 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_regfile.md
Name: alu_regfile

Overview:
- Register file and flag-holding stage wrapped around the ALU.
- Upstream: two combinational read ports drive ALU inA/inB; the shift-carry flag register drives ALU sc_i.
- Downstream: captures ALU rslt into a destination register, and sc_o/cnd into flag registers, at the clock edge.
- Also derives registered zero/parity flags from written data for later branch decisions.

Parameters:
- DW, 8, data width of each register and of the ALU data path
- AW, 3, register address width (2**AW registers)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports on address match; 0 = reads return stored value only

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  1 = suppress every write and flag update this cycle
- rd_addr_a  in  AW  read port A address (to ALU inA)
- rd_addr_b  in  AW  read port B address (to ALU inB)
- do_a  out  DW  read data A
- do_b  out  DW  read data B
- wr_en  in  1  register write enable
- wr_addr  in  AW  destination register
- wr_data  in  DW  write data (ALU rslt)
- sc_we  in  1  load shift-carry flag from sc_in
- sc_clr  in  1  clear shift-carry flag
- sc_in  in  1  ALU sc_o
- sc_q  out  1  registered shift-carry (to ALU sc_i)
- cnd_we  in  1  load condition flag from cnd_in
- cnd_in  in  1  ALU cnd
- cnd_q  out  1  registered condition flag
- flag_we  in  1  update zero/parity flags from wr_data
- zero_q  out  1  registered zero flag (wr_data == 0)
- pari_q  out  1  registered parity flag (XOR-reduce of wr_data)

Behaviour:
- Reset (async, any time, incl. mid-write):
  - all 2**AW registers = 0
  - sc_q = 0, cnd_q = 0, zero_q = 0, pari_q = 0
  - do_a/do_b therefore read 0 while reset is held
- Reads: combinational, zero latency. do_a = reg[rd_addr_a], do_b = reg[rd_addr_b].
- Bypass (BYPASS=1): if wr_en && !stall && wr_addr == rd_addr_x, do_x = wr_data in the same cycle. Applies to both ports independently, including when both addresses match.
- Write: at posedge, if wr_en && !stall, reg[wr_addr] <= wr_data. Exactly one register is written; all others hold. No hardwired-zero register.
- Shift-carry, evaluated at posedge only when !stall, in priority order:
  - sc_clr -> 0
  - else sc_we -> sc_in
  - else hold
- Condition: cnd_we && !stall -> cnd_q <= cnd_in; else hold.
- Zero/parity: flag_we && !stall -> zero_q <= (wr_data == 0), pari_q <= ^wr_data. Computed from wr_data regardless of wr_en; else hold.
- stall=1: every register and flag holds. Reads and bypass are suppressed to stored values.
- Latency: write -> visible on non-bypassed read the next cycle; flag update -> visible on outputs the next cycle.
- Widths: addresses wrap naturally within AW bits; no out-of-range case exists.

Decomposition:
- Shared package cpu_pkg holds:
  - DW and AW constants
  - reg_addr_t typedef (logic [AW-1:0]) and data_t typedef (logic [DW-1:0])
  - ALU command encodings (ADD, SUB, AND, XOR, CMP, CEQ, LSL, LSR, MOV) as a 5-bit enum, for the decoder that drives this block
- One sub-module: flag_bits, holding the four flag flops with sc_clr priority and stall gating. The register array stays in the top module.

Test Plan:
- Reset mid-operation: write R3=0x5A, then pulse reset asynchronously between edges -> do_a (rd_addr_a=3) reads 0x00 immediately; sc_q, cnd_q, zero_q, pari_q all 0.
- Write/readback: write R1=0xA5 and R7=0x3C on consecutive cycles -> next cycle rd_addr_a=1, rd_addr_b=7 gives do_a=0xA5, do_b=0x3C; other registers still 0.
- Bypass: cycle with wr_en=1, wr_addr=2, wr_data=0x77, rd_addr_a=rd_addr_b=2 -> do_a=do_b=0x77 in that cycle (BYPASS=1). With BYPASS=0 both read the old value 0x00.
- Carry priority: sc_we=1, sc_in=1, sc_clr=1 -> sc_q=0 after the edge. Next cycle sc_we=1, sc_in=1, sc_clr=0 -> sc_q=1. Next cycle no enables -> sc_q stays 1.
- Zero/parity: flag_we=1 with wr_data=0x00 -> zero_q=1, pari_q=0. Then wr_data=0x07 -> zero_q=0, pari_q=1. Then wr_data=0x03 -> pari_q=0.
- Stall: wr_en=1, wr_addr=4, wr_data=0xFF, sc_we=1, sc_in=1, cnd_we=1, cnd_in=1, stall=1 -> R4 stays 0x00, sc_q=0, cnd_q=0, no bypass (do_a=0x00 for rd_addr_a=4).
